// File: rtl/seq_scan_ctrl.sv
// Frame-based word serializer (MSB first) with a 4-bit masked pattern scanner
// running across the serial stream and a saturating per-frame match counter.
module seq_scan_ctrl #(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [3:0]        frame_len,
  input  logic [3:0]        pattern,
  input  logic [3:0]        mask,
  input  logic [WORD_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              x_out,
  output logic              x_valid,
  output logic              match,
  output logic [CNT_W-1:0]  match_count,
  output logic              busy,
  output logic              done
);

  localparam int BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [BW-1:0]    LAST_BIT = BW'(WORD_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_q;
  logic [3:0]        words_left_q;
  logic [3:0]        pat_q;
  logic [3:0]        mask_q;
  logic [WORD_W-1:0] sh_q;
  logic [BW-1:0]     bit_cnt_q;
  logic [3:0]        hist_q;
  logic [2:0]        fill_q;
  logic              data_ready_q;
  logic              x_out_q;
  logic              x_valid_q;
  logic              match_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q;
  logic              done_q;

  logic [3:0] hist_d;
  logic [2:0] fill_d;
  logic       hit_d;

  // The bit currently on x_out is folded into the history at the end of its cycle.
  always_comb begin
    hist_d = {hist_q[2:0], x_out_q};
    fill_d = (fill_q == 3'd4) ? 3'd4 : fill_q + 3'd1;
    hit_d  = x_valid_q && (fill_d == 3'd4) && (mask_q != 4'd0) &&
             (((hist_d ^ pat_q) & mask_q) == 4'd0);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      words_left_q <= '0;
      pat_q        <= '0;
      mask_q       <= '0;
      sh_q         <= '0;
      bit_cnt_q    <= '0;
      hist_q       <= '0;
      fill_q       <= '0;
      data_ready_q <= 1'b0;
      x_out_q      <= 1'b0;
      x_valid_q    <= 1'b0;
      match_q      <= 1'b0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      match_q <= hit_d;
      done_q  <= 1'b0;
      if (hit_d && (cnt_q != CNT_MAX)) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (x_valid_q) begin
        hist_q <= hist_d;
        fill_q <= fill_d;
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            words_left_q <= frame_len;
            pat_q        <= pattern;
            mask_q       <= mask;
            cnt_q        <= '0;
            hist_q       <= '0;
            fill_q       <= '0;
            if (frame_len != 4'd0) begin
              state_q      <= LOAD;
              data_ready_q <= 1'b1;
              busy_q       <= 1'b1;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end

        LOAD: begin
          if (data_valid) begin
            state_q      <= SHIFT;
            data_ready_q <= 1'b0;
            x_valid_q    <= 1'b1;
            x_out_q      <= data_in[WORD_W-1];
            sh_q         <= data_in << 1;
            bit_cnt_q    <= '0;
            words_left_q <= words_left_q - 4'd1;
          end
        end

        SHIFT: begin
          if (bit_cnt_q == LAST_BIT) begin
            x_valid_q <= 1'b0;
            x_out_q   <= 1'b0;
            if (words_left_q != 4'd0) begin
              state_q      <= LOAD;
              data_ready_q <= 1'b1;
            end else begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
            x_out_q   <= sh_q[WORD_W-1];
            sh_q      <= sh_q << 1;
          end
        end

        DONE: begin
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_ready  = data_ready_q;
  assign x_out       = x_out_q;
  assign x_valid     = x_valid_q;
  assign match       = match_q;
  assign match_count = cnt_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Scoreboard bench for seq_scan_ctrl: a stream-level reference model queues the
// expected bits, match flags and end-of-frame counts; a monitor consumes them.
module tb_seq_scan_ctrl;

  localparam int WORD_W = 8;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef logic [WORD_W-1:0] word_q_t[$];

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              start = 1'b0;
  logic [3:0]        frame_len = '0;
  logic [3:0]        pattern = '0;
  logic [3:0]        mask = '0;
  logic [WORD_W-1:0] data_in = '0;
  logic              data_valid = 1'b0;
  logic              data_ready;
  logic              x_out;
  logic              x_valid;
  logic              match;
  logic [CNT_W-1:0]  match_count;
  logic              busy;
  logic              done;

  seq_scan_ctrl #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .start(start), .frame_len(frame_len),
    .pattern(pattern), .mask(mask), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .x_out(x_out), .x_valid(x_valid), .match(match),
    .match_count(match_count), .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  bit exp_bit_q[$];
  bit exp_hit_q[$];
  int exp_cnt_q[$];
  bit mon_en = 1'b0;

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  // Monitor: compares every output cycle against the queued expectations.
  bit pend = 1'b0;
  bit mb, mh;
  int mc;
  always @(negedge CLK) begin
    if (!mon_en) begin
      pend = 1'b0;
    end else begin
      check("match_pulse", match, pend);
      if (x_valid) begin
        check("busy_in_shift", busy, 1);
        if (exp_bit_q.size() == 0) begin
          check("unexpected_bit", 1, 0);
          pend = 1'b0;
        end else begin
          mb = exp_bit_q.pop_front();
          mh = exp_hit_q.pop_front();
          check("x_out", x_out, mb);
          pend = mh;
        end
      end else begin
        check("x_out_quiet", x_out, 0);
        pend = 1'b0;
      end
      if (done) begin
        check("done_busy", busy, 0);
        check("done_ready", data_ready, 0);
        if (exp_cnt_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          mc = exp_cnt_q.pop_front();
          check("done_count", match_count, mc);
          $display("frame done: match_count=%0d expected=%0d", match_count, mc);
        end
      end
    end
  end

  // Reference: flatten the frame to a bit list, slide a 4-bit window over it.
  task automatic model(input logic [3:0] pat, input logic [3:0] msk,
                       input word_q_t w, output int cnt);
    bit s[$];
    int m = 0;
    logic [3:0] win;
    bit hit;
    foreach (w[j]) begin
      for (int k = WORD_W - 1; k >= 0; k--) s.push_back(w[j][k]);
    end
    for (int i = 0; i < s.size(); i++) begin
      hit = 1'b0;
      if (i >= 3 && msk != 4'd0) begin
        win = {s[i-3], s[i-2], s[i-1], s[i]};
        hit = (((win ^ pat) & msk) == 4'd0);
      end
      exp_bit_q.push_back(s[i]);
      exp_hit_q.push_back(hit);
      if (hit) m++;
    end
    cnt = (m > CNT_MAX) ? CNT_MAX : m;
    exp_cnt_q.push_back(cnt);
  endtask

  task automatic run_frame(input logic [3:0] pat, input logic [3:0] msk,
                           input word_q_t w, input bit junk);
    int cnt;
    bit acc;
    bit got;
    model(pat, msk, w, cnt);
    $display("frame: len=%0d pattern=%b mask=%b expected_count=%0d", w.size(), pat, msk, cnt);
    frame_len = 4'(w.size());
    pattern   = pat;
    mask      = msk;
    start     = 1'b1;
    @(posedge CLK); #1;
    start     = 1'b0;
    frame_len = 4'($urandom);
    pattern   = 4'($urandom);
    mask      = 4'($urandom);
    foreach (w[j]) begin
      repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
      data_valid = 1'b1;
      data_in    = w[j];
      acc = 1'b0;
      for (int t = 0; t < 50 && !acc; t++) begin
        acc = data_ready;
        @(posedge CLK); #1;
      end
      if (!acc) check("accept_timeout", 0, 1);
      data_valid = 1'b0;
      data_in    = WORD_W'($urandom);
      if (junk && $urandom_range(0, 1) == 1) begin
        start     = 1'b1;
        frame_len = 4'($urandom);
        pattern   = 4'($urandom);
        mask      = 4'($urandom);
        @(posedge CLK); #1;
        start = 1'b0;
      end
    end
    got = 1'b0;
    for (int t = 0; t < 100 && !got; t++) begin
      if (done) got = 1'b1;
      else begin @(posedge CLK); #1; end
    end
    if (!got) check("done_timeout", 0, 1);
    @(posedge CLK); #1;
    check("count_hold", match_count, cnt);
    check("idle_busy", busy, 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, data_ready, 0);
    check({tag, "_x_out"}, x_out, 0);
    check({tag, "_x_valid"}, x_valid, 0);
    check({tag, "_match"}, match, 0);
    check({tag, "_count"}, match_count, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  initial begin
    word_q_t w;
    bit acc;
    int n;

    // Reset held while start and data_valid are active: reset must win.
    start = 1'b1; frame_len = 4'd3; data_valid = 1'b1; data_in = 8'hA5;
    repeat (3) begin @(posedge CLK); #1; end
    check_idle_outputs("reset");
    start = 1'b0; data_valid = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b0;
    mon_en = 1'b1;
    @(posedge CLK); #1;

    w = {8'b10010010};           run_frame(4'b1001, 4'b1111, w, 0);
    w = {8'h09, 8'h20};          run_frame(4'b1001, 4'b1111, w, 0);
    w = {8'($urandom), 8'($urandom)}; run_frame(4'($urandom), 4'b0000, w, 0);
    w = {8'hFF};                 run_frame(4'b0001, 4'b0001, w, 0);
    w = {8'hFF, 8'hFF, 8'hFF};   run_frame(4'b0001, 4'b0001, w, 0);
    w = {};                      run_frame(4'b1001, 4'b1111, w, 0);
    w = {8'h09, 8'h20};          run_frame(4'b1001, 4'b1111, w, 1);

    // Reset during the third SHIFT cycle of the first word.
    mon_en = 1'b0;
    @(posedge CLK); #1;
    frame_len = 4'd2; pattern = 4'b1001; mask = 4'b1111; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    data_valid = 1'b1; data_in = 8'hFF;
    acc = 1'b0;
    for (int t = 0; t < 20 && !acc; t++) begin
      acc = data_ready;
      @(posedge CLK); #1;
    end
    if (!acc) check("rst_accept_timeout", 0, 1);
    data_valid = 1'b0;
    check("rst_shift_valid", x_valid, 1);
    repeat (2) begin @(posedge CLK); #1; end
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    check_idle_outputs("midrst");
    @(posedge CLK); #1;
    check("midrst_still_idle", busy, 0);
    mon_en = 1'b1;
    @(posedge CLK); #1;
    w = {8'b10010010};           run_frame(4'b1001, 4'b1111, w, 0);

    for (int r = 0; r < 40; r++) begin
      w = {};
      n = $urandom_range(0, 4);
      for (int j = 0; j < n; j++) w.push_back(WORD_W'($urandom));
      run_frame(4'($urandom), 4'($urandom), w, 1);
    end

    repeat (3) begin @(posedge CLK); #1; end
    check("leftover_bits", exp_bit_q.size(), 0);
    check("leftover_counts", exp_cnt_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_scan_ctrl.md
SEQ_SCAN_CTRL -- requirements
Module: seq_scan_ctrl

Interface
REQ-001 Parameter WORD_W, default 8: width of each data word, serialized MSB first.
REQ-002 Parameter CNT_W, default 8: width of match_count.
REQ-003 CLK  in  1  single clock; all state changes on posedge CLK.
REQ-004 RST  in  1  synchronous, active-high reset, sampled on posedge CLK.
REQ-005 start  in  1  begin a frame; sampled only in IDLE.
REQ-006 frame_len  in  4  number of words in the frame, 0..15; sampled with start.
REQ-007 pattern  in  4  target bit pattern; bit 0 = newest stream bit; sampled with start.
REQ-008 mask  in  4  per-bit compare enable for pattern; sampled with start.
REQ-009 data_in  in  WORD_W  word to serialize.
REQ-010 data_valid  in  1  data_in is valid.
REQ-011 data_ready  out  1  block accepts a word this cycle.
REQ-012 x_out  out  1  serial stream bit.
REQ-013 x_valid  out  1  x_out carries a stream bit this cycle.
REQ-014 match  out  1  one-cycle pulse per detected pattern occurrence.
REQ-015 match_count  out  CNT_W  saturating count of matches in the current or last frame.
REQ-016 busy  out  1  high in LOAD and SHIFT.
REQ-017 done  out  1  one-cycle pulse marking the end of a frame.

Function
REQ-018 States SHALL be IDLE, LOAD, SHIFT, DONE.
REQ-019 IDLE with start=1 SHALL latch frame_len/pattern/mask, clear match_count, history and fill counter, and go to LOAD (frame_len>0) or DONE (frame_len=0).
REQ-020 start outside IDLE SHALL be ignored, and latched settings SHALL hold until the next accepted start.
REQ-021 data_ready SHALL be 1 only in LOAD.
REQ-022 A word SHALL be accepted on the edge where data_valid and data_ready are both 1; LOAD then goes to SHIFT, otherwise LOAD holds indefinitely.
REQ-023 SHIFT SHALL last exactly WORD_W cycles, with x_valid=1 and x_out = the accepted word bit WORD_W-1 down to bit 0, one bit per cycle.
REQ-024 x_valid SHALL be 0 and x_out SHALL be 0 in IDLE, LOAD and DONE.
REQ-025 After the last SHIFT cycle, the FSM SHALL go to LOAD if words remain and to DONE otherwise, giving a minimum of one bubble cycle between words.
REQ-026 On each x_valid cycle, history[3:0] SHALL update to {history[2:0], x_out}, and the fill counter SHALL increment, saturating at 4.
REQ-027 A match SHALL occur when updated fill=4, mask!=0, and ((updated history ^ pattern) & mask)=0.
REQ-028 match SHALL pulse the cycle after the completing bit's x_valid cycle, and match_count SHALL increment on the same edge, holding at 2^CNT_W-1.
REQ-029 History and fill SHALL persist across word boundaries within a frame, so patterns spanning two words are detected.
REQ-030 DONE SHALL last one cycle with done=1, busy=0, then go to IDLE; a match from the final bit appears in the DONE cycle and is included in match_count during that cycle.
REQ-031 match_count SHALL hold its value after DONE until the next accepted start.

Reset
REQ-032 RST=1 SHALL force IDLE on the next edge from any state, discarding any in-flight word and frame.
REQ-033 RST=1 SHALL take precedence over start and over the data handshake.
REQ-034 Reset values SHALL be: data_ready=0, x_out=0, x_valid=0, match=0, match_count=0, busy=0, done=0, history=0, fill=0, latched settings=0.

Verification
REQ-035 frame_len=1, pattern=4'b1001, mask=4'b1111, word 8'b10010010 -> x_out sequence 1,0,0,1,0,0,1,0; match after bits 4 and 7; match_count=2 at done.
REQ-036 frame_len=2, same pattern and mask, words 8'h09 then 8'h20 -> matches after stream bits 8 and 11 (the second spans the word boundary); match_count=2; at least one cycle with data_ready=1 between the two SHIFT phases.
REQ-037 mask=4'b0000, any data -> no match pulses, match_count=0; mask=4'b0001, pattern=4'b0001, word 8'hFF, frame_len=1 -> 5 matches (bits 4..8).
REQ-038 CNT_W=4, mask=4'b0001, pattern=4'b0001, frame_len=3, words 8'hFF -> 21 qualifying bits, match_count saturates at 15 with no wrap.
REQ-039 Assert RST for one cycle during the third SHIFT cycle of word 1 -> next cycle shows IDLE outputs with match_count=0; a subsequent start runs a clean frame.
REQ-040 start pulsed in SHIFT, and frame_len=0 accepted in IDLE -> the SHIFT start is ignored with no setting change; the frame_len=0 frame gives done on the cycle after start with match_count=0 and data_ready never asserted.
